bcd_modn_counter: RTL

- Parametrised BCD modulo-N counter. Generalises the fixed mod-60 tens/units counter to any digit count and modulus.
- Adds up/down counting, synchronous load, count enable, a cascade terminal-count output, a wrap pulse and a load-error flag.
- Used for clock/timer digit chains (seconds, minutes, hours) and is cascadable through tc → en of the next stage.

---
 rtl/bcd_modn_counter_if.sv | 22 ++
 rtl/bcd_modn_counter.sv | 102 ++++++++++
 2 files changed

// File: rtl/bcd_modn_counter_if.sv
// bcd_modn_counter_if: control/status bundle for bcd_modn_counter.
// The seg field exists only when BCD_MODN_SEG7_EN is defined.
interface bcd_modn_counter_if #(
    parameter int DIGITS = 2
);
    logic                en;
    logic                up;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] bcd;
    logic                tc;
    logic                wrap;
    logic                err;
`ifdef BCD_MODN_SEG7_EN
    logic [7*DIGITS-1:0] seg;
    modport master (output en, up, load, load_val, input bcd, tc, wrap, err, seg);
    modport slave  (input en, up, load, load_val, output bcd, tc, wrap, err, seg);
`else
    modport master (output en, up, load, load_val, input bcd, tc, wrap, err);
    modport slave  (input en, up, load, load_val, output bcd, tc, wrap, err);
`endif
endinterface

// File: rtl/bcd_modn_counter.sv
// bcd_modn_counter: parametrised up/down BCD modulo-N counter with load, cascade tc, wrap and err.
// Optional active-low 7-segment output enabled by BCD_MODN_SEG7_EN.
module bcd_modn_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input logic               clk,
    input logic               rst,
    bcd_modn_counter_if.slave bus
);
    localparam int W = 4 * DIGITS;

    function automatic longint pow10(int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [W-1:0] to_bcd(int v);
        logic [W-1:0] b = '0;
        int r = v;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    function automatic logic digits_ok(logic [W-1:0] v);
        logic ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) ok = ok & (v[4*i +: 4] <= 4'd9);
        return ok;
    endfunction

    if (MODULUS < 2 || longint'(MODULUS) > pow10(DIGITS)) begin : g_bad_modulus
        $error("bcd_modn_counter: MODULUS %0d outside 2..10**%0d", MODULUS, DIGITS);
    end

    localparam logic [W-1:0] max_bcd = to_bcd(MODULUS - 1);

    logic [W-1:0] inc_val, dec_val, step_val;
    logic         carry, borrow, hit, bcd_ok, load_ok, tc_i;

    // Ripple per-nibble carry/borrow: a digit moves only when all lower digits are at 9 (up) or 0 (down).
    always_comb begin
        inc_val = bus.bcd;
        dec_val = bus.bcd;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry)  inc_val[4*i +: 4] = (bus.bcd[4*i +: 4] == 4'd9) ? 4'd0 : bus.bcd[4*i +: 4] + 4'd1;
            if (borrow) dec_val[4*i +: 4] = (bus.bcd[4*i +: 4] == 4'd0) ? 4'd9 : bus.bcd[4*i +: 4] - 4'd1;
            carry  = carry  & (bus.bcd[4*i +: 4] == 4'd9);
            borrow = borrow & (bus.bcd[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        hit      = bus.up ? (bus.bcd == max_bcd) : (bus.bcd == '0);
        bcd_ok   = digits_ok(bus.bcd) && (bus.bcd <= max_bcd);
        load_ok  = digits_ok(bus.load_val) && (bus.load_val <= max_bcd);
        tc_i     = bus.en & ~bus.load & hit;
        step_val = !bcd_ok ? '0 : hit ? (bus.up ? '0 : max_bcd) : (bus.up ? inc_val : dec_val);
    end

    assign bus.tc = tc_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bcd  <= '0;
            bus.wrap <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.bcd  <= bus.load ? (load_ok ? bus.load_val : bus.bcd) : bus.en ? step_val : bus.bcd;
            bus.wrap <= tc_i;
            bus.err  <= bus.load & ~load_ok;
        end
    end

`ifdef BCD_MODN_SEG7_EN
    function automatic logic [6:0] seg7(logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        bus.seg = '1;
        for (int i = 0; i < DIGITS; i++) bus.seg[7*i +: 7] = seg7(bus.bcd[4*i +: 4]);
    end
`endif
endmodule
